dac_hpf_bank: RTL and testbench

Parametrised N-channel successor to the single-channel AD5662 DAC driver. It accepts one sample vector per frame through a valid/ready handshake and processes channels one at a time through a shared datapath:
- one-pole high-pass filter with per-channel state;
- noise suppression;
- saturating gain;
- threshold comparator.

Each channel is then shifted out as a 24-bit AD5662 frame on a shared SCLK/DIN pair with a per-channel SYNC. The block sits between the sample-capture logic and the board DAC/digital-out pins, replacing N separate DAC driver instances.

---
 rtl/dac_hpf_bank.sv | 241 ++++++++++++++++++++++++
 tb/tb_dac_hpf_bank.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_hpf_bank.sv
// dac_hpf_bank
//
// N-channel DAC driver with a shared per-channel datapath. One sample vector
// is accepted per frame through a valid/ready handshake. Each channel then
// runs through a one-pole high-pass filter with its own state, a noise
// dead-band, a saturating power-of-two gain and a threshold comparator. The
// result is shifted out as a 24-bit AD5662 frame on a shared SCLK/DIN pair,
// with one active-low SYNC line per channel.
//
// Ports:
//   state_clk       block clock
//   reset           synchronous, active-high reset
//   sample_valid    sample vector available
//   sample_ready    high while idle; a vector is accepted when both are high
//   sample_data     offset-binary samples, channel k at [16k+15:16k]
//   ch_en           per-channel enable (a disabled channel sends mid-scale)
//   hpf_en          0 bypasses the HPF on the output path
//   hpf_coef        HPF coefficient B = hpf_coef / 2^16
//   gain            output gain 2^gain, saturating
//   noise_suppress  dead-band half-width in units of 16 LSB
//   thrsh           comparator threshold, offset-binary
//   thrsh_pol       1: out = y >= thrsh, 0: out = y <= thrsh
//   thrsh_out       registered comparator result per channel
//   dac_sclk        shared SPI clock (DAC samples DIN on its falling edge)
//   dac_din         shared SPI data, MSB first
//   dac_sync        per-channel active-low frame select

module dac_hpf_bank #(
    parameter int NUM_CH   = 8,
    parameter int SCLK_DIV = 1
) (
    input  logic                  state_clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [16*NUM_CH-1:0]  sample_data,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic                  hpf_en,
    input  logic [15:0]           hpf_coef,
    input  logic [2:0]            gain,
    input  logic [6:0]            noise_suppress,
    input  logic [15:0]           thrsh,
    input  logic                  thrsh_pol,
    output logic [NUM_CH-1:0]     thrsh_out,
    output logic                  dac_sclk,
    output logic                  dac_din,
    output logic [NUM_CH-1:0]     dac_sync
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        UPD,
        SHIFT,
        GAP
    } fsm_t;

    fsm_t               fsm;
    logic [CH_W-1:0]    ch;
    logic [DIV_W-1:0]   div_cnt;
    logic [4:0]         bit_cnt;
    logic [22:0]        shreg;
    logic signed [17:0] diff_q;
    logic [31:0]        hpf_state [NUM_CH];

    // Frame snapshot: configuration is frozen at acceptance so that changes
    // made mid-frame only take effect on the next frame.
    logic [16*NUM_CH-1:0] snap_data;
    logic [NUM_CH-1:0]    snap_en;
    logic                 snap_hpf_en;
    logic [15:0]          snap_coef;
    logic [2:0]           snap_gain;
    logic [6:0]           snap_ns;
    logic [15:0]          snap_thrsh;
    logic                 snap_pol;

    // Datapath nets
    logic [15:0]        d_cur;
    logic signed [17:0] x_cur;
    logic signed [17:0] s_cur;
    logic signed [18:0] diff_wide;
    logic signed [17:0] diff_sat;
    logic signed [35:0] prod;
    logic [31:0]        state_inc;
    logic signed [15:0] h;
    logic [15:0]        y;
    logic               cmp;
    logic signed [16:0] ns_amt;
    logic signed [16:0] h_ext;
    logic signed [16:0] ns_tmp;
    logic signed [15:0] h_den;
    logic signed [23:0] g_wide;
    logic [15:0]        g_sat;
    logic [15:0]        word;
    logic [NUM_CH-1:0]  sync_sel;

    always_comb begin
        d_cur     = snap_data[{ch, 4'b0000} +: 16];
        // Offset-binary to signed, scaled by 4 to give the filter two guard bits.
        x_cur     = $signed({~d_cur[15], d_cur[14:0], 2'b00});
        s_cur     = $signed(hpf_state[ch][31:14]);
        diff_wide = {x_cur[17], x_cur} - {s_cur[17], s_cur};
        if (diff_wide[18] != diff_wide[17])
            diff_sat = diff_wide[18] ? 18'sh20000 : 18'sh1FFFF;
        else
            diff_sat = diff_wide[17:0];

        // diff * B with B in 2^-16 units; bits [34:3] land on the 2^-14 scale
        // of the 32-bit state, whose top 18 bits line up with x.
        prod      = diff_q * $signed({1'b0, snap_coef, 1'b0});
        state_inc = 32'(prod >>> 3);

        h   = snap_hpf_en ? diff_q[17:2] : x_cur[17:2];
        y   = {~h[15], h[14:0]};
        cmp = snap_pol ? (y >= snap_thrsh) : (y <= snap_thrsh);

        // Dead-band pulls the magnitude toward zero without crossing it.
        ns_amt = $signed({6'b000000, snap_ns, 4'b0000});
        h_ext  = {h[15], h};
        ns_tmp = h_ext;
        h_den  = 16'sd0;
        if (h_ext > 17'sd0) begin
            ns_tmp = h_ext - ns_amt;
            h_den  = (ns_tmp < 17'sd0) ? 16'sd0 : ns_tmp[15:0];
        end else if (h_ext < 17'sd0) begin
            ns_tmp = h_ext + ns_amt;
            h_den  = (ns_tmp > 17'sd0) ? 16'sd0 : ns_tmp[15:0];
        end

        // Max shift of 7 on a 16-bit value fits in 24 bits before clamping.
        g_wide = {{8{h_den[15]}}, h_den};
        g_wide = g_wide <<< snap_gain;
        if (g_wide > 24'sd32767)
            g_sat = 16'h7FFF;
        else if (g_wide < -24'sd32768)
            g_sat = 16'h8000;
        else
            g_sat = g_wide[15:0];

        word = snap_en[ch] ? {~g_sat[15], g_sat[14:0]} : 16'h8000;

        sync_sel     = '1;
        sync_sel[ch] = 1'b0;
    end

    always_ff @(posedge state_clk) begin
        if (reset) begin
            fsm          <= IDLE;
            ch           <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            diff_q       <= '0;
            sample_ready <= 1'b1;
            thrsh_out    <= '0;
            dac_sclk     <= 1'b0;
            dac_din      <= 1'b0;
            dac_sync     <= '1;
            snap_data    <= '0;
            snap_en      <= '0;
            snap_hpf_en  <= 1'b0;
            snap_coef    <= '0;
            snap_gain    <= '0;
            snap_ns      <= '0;
            snap_thrsh   <= '0;
            snap_pol     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                hpf_state[i] <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (sample_valid) begin
                        snap_data    <= sample_data;
                        snap_en      <= ch_en;
                        snap_hpf_en  <= hpf_en;
                        snap_coef    <= hpf_coef;
                        snap_gain    <= gain;
                        snap_ns      <= noise_suppress;
                        snap_thrsh   <= thrsh;
                        snap_pol     <= thrsh_pol;
                        ch           <= '0;
                        sample_ready <= 1'b0;
                        fsm          <= SUB;
                    end
                end
                SUB: begin
                    diff_q <= diff_sat;
                    fsm    <= UPD;
                end
                UPD: begin
                    // The filter state tracks the input even when the HPF is
                    // bypassed, so enabling it later starts from a settled value.
                    hpf_state[ch] <= snap_en[ch] ? (hpf_state[ch] + state_inc) : '0;
                    thrsh_out[ch] <= snap_en[ch] & cmp;
                    // Bit 23 goes out now; shreg keeps the 23 bits still to send.
                    shreg         <= {7'h00, word};
                    dac_din       <= 1'b0;
                    dac_sclk      <= 1'b1;
                    dac_sync      <= sync_sel;
                    div_cnt       <= '0;
                    bit_cnt       <= '0;
                    fsm           <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (dac_sclk) begin
                            dac_sclk <= 1'b0;
                        end else if (bit_cnt == 5'd23) begin
                            dac_sync <= '1;
                            dac_din  <= 1'b0;
                            fsm      <= GAP;
                        end else begin
                            dac_sclk <= 1'b1;
                            dac_din  <= shreg[22];
                            shreg    <= {shreg[21:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        ch           <= '0;
                        sample_ready <= 1'b1;
                        fsm          <= IDLE;
                    end else begin
                        ch  <= ch + CH_W'(1);
                        fsm <= SUB;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_hpf_bank.sv
// Testbench for dac_hpf_bank. Directed frames for the filter, gain, dead-band,
// comparator and reset-abort cases, followed by randomized frames. Expected
// SPI words and comparator bits come from an integer model of the channel
// arithmetic; SPI frames are reassembled from the pins by a monitor.

module tb_dac_hpf_bank;

    localparam int NUM_CH   = 4;
    localparam int SCLK_DIV = 2;
    localparam int T_CH     = 3 + 48 * SCLK_DIV;
    localparam int FRAME    = 1 + NUM_CH * T_CH;

    logic                 state_clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 sample_valid = 1'b0;
    logic                 sample_ready;
    logic [16*NUM_CH-1:0] sample_data = '0;
    logic [NUM_CH-1:0]    ch_en = '0;
    logic                 hpf_en = 1'b0;
    logic [15:0]          hpf_coef = '0;
    logic [2:0]           gain = '0;
    logic [6:0]           noise_suppress = '0;
    logic [15:0]          thrsh = '0;
    logic                 thrsh_pol = 1'b0;
    logic [NUM_CH-1:0]    thrsh_out;
    logic                 dac_sclk;
    logic                 dac_din;
    logic [NUM_CH-1:0]    dac_sync;

    dac_hpf_bank #(
        .NUM_CH   (NUM_CH),
        .SCLK_DIV (SCLK_DIV)
    ) dut (
        .state_clk      (state_clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_data    (sample_data),
        .ch_en          (ch_en),
        .hpf_en         (hpf_en),
        .hpf_coef       (hpf_coef),
        .gain           (gain),
        .noise_suppress (noise_suppress),
        .thrsh          (thrsh),
        .thrsh_pol      (thrsh_pol),
        .thrsh_out      (thrsh_out),
        .dac_sclk       (dac_sclk),
        .dac_din        (dac_din),
        .dac_sync       (dac_sync)
    );

    always #5 state_clk = ~state_clk;

    int cyc = 0;
    always @(posedge state_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI monitor: rebuilds each SYNC-low window from the pins.
    typedef struct {
        int          ch;
        logic [23:0] word;
        int          edges;
        int          low;
        int          start;
    } win_t;

    win_t              win_q[$];
    bit                in_win = 0;
    bit                prev_sclk = 0;
    int                w_ch, w_edges, w_low, w_start;
    logic [23:0]       w_word;
    logic [NUM_CH-1:0] w_sync;
    bit                multi_low = 0;
    bit                idle_glitch = 0;
    bit                sync_change = 0;

    always @(negedge state_clk) begin
        if (reset) begin
            in_win    = 0;
            prev_sclk = 0;
        end else begin
            if ($countones(~dac_sync) > 1) multi_low = 1;
            if (in_win && dac_sync == '1) begin
                win_q.push_back('{w_ch, w_word, w_edges, w_low, w_start});
                in_win = 0;
            end else if (!in_win && dac_sync != '1) begin
                in_win  = 1;
                w_sync  = dac_sync;
                w_edges = 0;
                w_low   = 0;
                w_word  = '0;
                w_start = cyc;
                w_ch    = -1;
                for (int i = 0; i < NUM_CH; i++)
                    if (!dac_sync[i]) w_ch = i;
            end
            if (in_win) begin
                if (dac_sync != w_sync) sync_change = 1;
                w_low++;
                if (prev_sclk && !dac_sclk) begin
                    w_word = {w_word[22:0], dac_din};
                    w_edges++;
                end
            end else if (dac_sclk || dac_din) begin
                idle_glitch = 1;
            end
            prev_sclk = dac_sclk;
        end
    end

    // Frame configuration and reference model
    logic [16*NUM_CH-1:0] cfg_data;
    logic [NUM_CH-1:0]    cfg_en;
    bit                   cfg_hpf;
    int                   cfg_coef, cfg_gain, cfg_ns, cfg_thrsh;
    bit                   cfg_pol;

    int                m_state [NUM_CH];
    int                exp_word [NUM_CH];
    logic [NUM_CH-1:0] exp_thr;
    int                last_words [NUM_CH];

    function automatic void modelFrame();
        int d, x, s, diff, h, n, g;
        longint p;
        logic [15:0] dv;
        for (int k = 0; k < NUM_CH; k++) begin
            dv   = cfg_data[16*k +: 16];
            d    = {16'h0000, dv};
            x    = (d - 32768) * 4;
            s    = m_state[k] >>> 14;
            diff = x - s;
            if (diff > 131071) diff = 131071;
            if (diff < -131072) diff = -131072;
            if (cfg_en[k]) begin
                p = longint'(diff) * longint'(cfg_coef) * 2;
                m_state[k] = m_state[k] + int'(p >>> 3);
            end else begin
                m_state[k] = 0;
            end
            h = cfg_hpf ? (diff >>> 2) : (d - 32768);
            exp_thr[k] = cfg_en[k] && (cfg_pol ? (h + 32768 >= cfg_thrsh) : (h + 32768 <= cfg_thrsh));
            n = 0;
            if (h > 0) n = (h - cfg_ns * 16 > 0) ? h - cfg_ns * 16 : 0;
            if (h < 0) n = (h + cfg_ns * 16 < 0) ? h + cfg_ns * 16 : 0;
            g = n * (1 << cfg_gain);
            if (g > 32767) g = 32767;
            if (g < -32768) g = -32768;
            exp_word[k] = cfg_en[k] ? g + 32768 : 32768;
        end
    endfunction

    task automatic setBase();
        cfg_en    = '1;
        cfg_hpf   = 0;
        cfg_coef  = 0;
        cfg_gain  = 0;
        cfg_ns    = 0;
        cfg_thrsh = 16'h8000;
        cfg_pol   = 1;
        cfg_data  = '0;
    endtask

    task automatic driveCfg();
        sample_data    = cfg_data;
        ch_en          = cfg_en;
        hpf_en         = cfg_hpf;
        hpf_coef       = 16'(cfg_coef);
        gain           = 3'(cfg_gain);
        noise_suppress = 7'(cfg_ns);
        thrsh          = 16'(cfg_thrsh);
        thrsh_pol      = cfg_pol;
    endtask

    task automatic waitReady();
        int guard = 0;
        while (sample_ready !== 1'b1 && guard < 4 * FRAME) begin
            @(negedge state_clk);
            guard++;
        end
    endtask

    // Runs one full frame from the current cfg_* values and checks handshake
    // timing, every SPI window and the comparator outputs.
    task automatic applyStimulus(input int hold_extra);
        int acc;
        win_t w;
        waitReady();
        checkOutput("ready_before_frame", {31'd0, sample_ready}, 32'd1);
        driveCfg();
        sample_valid = 1'b1;
        @(negedge state_clk);
        acc = cyc;
        checkOutput("ready_drop", {31'd0, sample_ready}, 32'd0);
        modelFrame();
        for (int i = 0; i < hold_extra; i++) begin
            for (int j = 0; j < NUM_CH; j++) sample_data[16*j +: 16] = 16'($urandom);
            ch_en = NUM_CH'($urandom);
            @(negedge state_clk);
        end
        sample_valid = 1'b0;
        waitReady();
        checkOutput("busy_cycles", cyc - acc, NUM_CH * T_CH);
        checkOutput("window_count", win_q.size(), NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            if (win_q.size() > 0) begin
                w = win_q.pop_front();
                checkOutput($sformatf("win_ch_%0d", k), w.ch, k);
                checkOutput($sformatf("spi_word_ch%0d", k), {8'h00, w.word}, exp_word[k]);
                checkOutput($sformatf("sclk_falls_ch%0d", k), w.edges, 24);
                checkOutput($sformatf("sync_low_ch%0d", k), w.low, 48 * SCLK_DIV);
                checkOutput($sformatf("sync_start_ch%0d", k), w.start, acc + k * T_CH + 2);
                last_words[k] = {16'h0000, w.word[15:0]};
            end
        end
        checkOutput("thrsh_out", {28'd0, thrsh_out}, {28'd0, exp_thr});
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int guard;
        for (int k = 0; k < NUM_CH; k++) m_state[k] = 0;

        // Reset values
        repeat (3) @(posedge state_clk);
        #1;
        checkOutput("rst_ready", {31'd0, sample_ready}, 32'd1);
        checkOutput("rst_sync", {28'd0, dac_sync}, {28'd0, {NUM_CH{1'b1}}});
        checkOutput("rst_sclk", {31'd0, dac_sclk}, 32'd0);
        checkOutput("rst_din", {31'd0, dac_din}, 32'd0);
        checkOutput("rst_thrsh_out", {28'd0, thrsh_out}, 32'd0);
        reset = 1'b0;
        @(negedge state_clk);

        // Plain passthrough, filter state still advancing underneath
        setBase();
        cfg_coef = 16'h4000;
        cfg_data[15:0]  = 16'h9234;
        cfg_data[31:16] = 16'h1000;
        cfg_data[47:32] = 16'h8000;
        cfg_data[63:48] = 16'hFFFF;
        applyStimulus(0);
        checkOutput("pass_ch0", last_words[0], 32'h9234);
        checkOutput("pass_ch1", last_words[1], 32'h1000);

        // Disabled channels send mid-scale and clear their filter state
        cfg_en = 4'b0101;
        applyStimulus(2);
        checkOutput("dis_word_ch1", last_words[1], 32'h8000);
        checkOutput("dis_thr_ch1", {31'd0, thrsh_out[1]}, 32'd0);

        // Cleared state on ch1 means the first HPF output is the full step
        cfg_en   = '1;
        cfg_hpf  = 1;
        cfg_coef = 16'h8000;
        cfg_data[31:16] = 16'hC000;
        applyStimulus(0);
        checkOutput("dis_state_zero_ch1", last_words[1], 32'hC000);

        // Gain saturation at both rails and an exact negative full-scale
        setBase();
        cfg_gain = 3;
        cfg_data[15:0]  = 16'h9000;
        cfg_data[31:16] = 16'h7000;
        cfg_data[47:32] = 16'h8100;
        cfg_data[63:48] = 16'h0000;
        applyStimulus(0);
        checkOutput("gain_sat_pos", last_words[0], 32'hFFFF);
        checkOutput("gain_exact_neg", last_words[1], 32'h0000);

        // Dead-band clamps small values to zero and shrinks larger ones
        setBase();
        cfg_ns = 1;
        cfg_data[15:0]  = 16'h800A;
        cfg_data[31:16] = 16'h7FF6;
        cfg_data[47:32] = 16'h8020;
        cfg_data[63:48] = 16'h7FE0;
        applyStimulus(1);
        checkOutput("ns_clamp_pos", last_words[0], 32'h8000);
        checkOutput("ns_clamp_neg", last_words[1], 32'h8000);

        // Comparator at the threshold for both polarities
        setBase();
        cfg_thrsh = 16'h9000;
        cfg_pol   = 1;
        cfg_data[15:0]  = 16'h9000;
        cfg_data[31:16] = 16'h8FFF;
        applyStimulus(0);
        checkOutput("thr_pol1_eq", {31'd0, thrsh_out[0]}, 32'd1);
        cfg_pol = 0;
        cfg_data[15:0]  = 16'h9001;
        cfg_data[31:16] = 16'h9000;
        applyStimulus(0);
        checkOutput("thr_pol0_above", {31'd0, thrsh_out[0]}, 32'd0);
        checkOutput("thr_pol0_eq", {31'd0, thrsh_out[1]}, 32'd1);

        // Reset in the middle of a SPI frame aborts it and clears filter state
        setBase();
        cfg_hpf  = 1;
        cfg_coef = 16'h8000;
        for (int k = 0; k < NUM_CH; k++) cfg_data[16*k +: 16] = 16'hC000;
        waitReady();
        driveCfg();
        sample_valid = 1'b1;
        @(negedge state_clk);
        sample_valid = 1'b0;
        guard = 0;
        while (!(in_win && w_edges >= 10) && guard < 4 * FRAME) begin
            @(negedge state_clk);
            guard++;
        end
        checkOutput("abort_reached_bit10", {31'd0, in_win}, 32'd1);
        reset = 1'b1;
        @(posedge state_clk);
        #1;
        checkOutput("abort_sync", {28'd0, dac_sync}, {28'd0, {NUM_CH{1'b1}}});
        checkOutput("abort_sclk", {31'd0, dac_sclk}, 32'd0);
        checkOutput("abort_din", {31'd0, dac_din}, 32'd0);
        checkOutput("abort_ready", {31'd0, sample_ready}, 32'd1);
        checkOutput("abort_thrsh_out", {28'd0, thrsh_out}, 32'd0);
        @(posedge state_clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < NUM_CH; k++) m_state[k] = 0;
        win_q.delete();
        @(negedge state_clk);

        // Constant input through the HPF decays toward mid-scale
        prev = 0;
        for (int f = 0; f < 5; f++) begin
            applyStimulus(0);
            if (f == 0)
                checkOutput("hpf_first_word", last_words[0], 32'hC000);
            else
                checkOutput($sformatf("hpf_decay_f%0d", f),
                            {31'd0, (last_words[0] <= prev) && (last_words[0] >= 32'h8000)}, 32'd1);
            prev = last_words[0];
        end

        // Randomized frames, some with sample_valid held through the busy period
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < NUM_CH; k++) cfg_data[16*k +: 16] = 16'($urandom);
            cfg_en    = NUM_CH'($urandom);
            cfg_hpf   = 1'($urandom);
            cfg_coef  = int'($urandom_range(0, 65535));
            cfg_gain  = int'($urandom_range(0, 7));
            cfg_ns    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 4));
            cfg_thrsh = int'($urandom_range(0, 65535));
            cfg_pol   = 1'($urandom);
            applyStimulus(int'($urandom_range(0, 4)));
        end

        checkOutput("one_sync_low", {31'd0, multi_low}, 32'd0);
        checkOutput("idle_pins_quiet", {31'd0, idle_glitch}, 32'd0);
        checkOutput("sync_stable_in_window", {31'd0, sync_change}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
